// File: rtl/wallace_mult_pipe.sv
// ---------------------------------------------------------------------------
// wallace_mult_pipe
//
// Three-stage pipelined WIDTH x WIDTH multiplier. The block handles unsigned
// operands and two's-complement operands, and the mode is chosen per request.
// Signed products use Baugh-Wooley partial products, so every product row is
// a plain bit vector. A 3:2 carry-save (Wallace) tree reduces the rows to a
// sum row and a carry row. A carry-propagate adder then forms the product.
//
//   S1 (_p0) : registers a, b, tc. The partial products are formed from
//              these registers.
//   S2 (_p1) : registers the two rows left after Wallace reduction.
//   S3 (z)   : registers the final sum. out_valid is the S3 valid flag.
//
// A single advance enable (adv = !out_valid | out_ready) moves the whole
// pipeline. Bubbles are not collapsed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a, b       operands, WIDTH bits
//   tc         1 = two's-complement operands, 0 = unsigned
//   in_valid   a/b/tc carry a request
//   in_ready   request accepted this cycle (equal to adv)
//   z          product, PWIDTH bits
//   out_valid  z is valid
//   out_ready  consumer takes z this cycle
//   occ        number of valid stages, 0..3
//
// WIDTH must be even and between 8 and 64. PWIDTH is derived from WIDTH and
// must keep its default value.
// ---------------------------------------------------------------------------
module wallace_mult_pipe #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              tc,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PWIDTH-1:0] z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        occ
);

  // There is one row per multiplier bit. One extra row holds the
  // Baugh-Wooley correction constant.
  localparam int NROWS = WIDTH + 1;

  typedef logic [NROWS-1:0][PWIDTH-1:0] rows_t;
  typedef logic [1:0][PWIDTH-1:0]       pair_t;

  // Returns the number of 3:2 levels needed to bring n rows down to two.
  function automatic int wallace_levels(input int n);
    int cnt;
    int lvl;
    cnt = n;
    lvl = 0;
    while (cnt > 2) begin
      cnt = 2 * (cnt / 3) + (cnt % 3);
      lvl++;
    end
    return lvl;
  endfunction

  localparam int NLVL = wallace_levels(NROWS);

  // Builds the partial-product rows, already shifted into product position.
  // In signed mode, a cross term is inverted when exactly one of its two
  // operand bits is a sign bit. The constant 2^WIDTH + 2^(PWIDTH-1) is then
  // added. Together these reproduce the negative weight of the sign bits,
  // modulo 2^PWIDTH.
  function automatic rows_t bw_rows(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic             sgn);
    rows_t r;
    logic  bit_v;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        bit_v = x[j] & y[i];
        if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1)))
          bit_v = ~bit_v;
        r[i][i+j] = bit_v;
      end
    end
    if (sgn) begin
      r[WIDTH][WIDTH]    = 1'b1;
      r[WIDTH][PWIDTH-1] = 1'b1;
    end
    return r;
  endfunction

  // Wallace reduction. At each level, the rows are taken in groups of three,
  // and each group is compressed to a sum row and a carry row. Rows left
  // over at the end of a level pass through unchanged. The carry that leaves
  // the top bit has weight 2^PWIDTH, so it can be dropped: the true product
  // always fits in PWIDTH bits.
  function automatic pair_t wallace_reduce(input rows_t in_rows);
    rows_t cur;
    rows_t nxt;
    int    cnt;
    int    grp;
    cur = in_rows;
    cnt = NROWS;
    for (int lvl = 0; lvl < NLVL; lvl++) begin
      nxt = '0;
      grp = cnt / 3;
      for (int g = 0; g < NROWS / 3; g++) begin
        if (g < grp) begin
          nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
          nxt[2*g+1] = ((cur[3*g]   & cur[3*g+1]) |
                        (cur[3*g]   & cur[3*g+2]) |
                        (cur[3*g+1] & cur[3*g+2])) << 1;
        end
      end
      for (int r = 0; r < NROWS; r++) begin
        if (r >= 3 * grp && r < cnt)
          nxt[r-grp] = cur[r];
      end
      cnt = 2 * grp + (cnt - 3 * grp);
      cur = nxt;
    end
    return {cur[1], cur[0]};
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  logic              adv;
  logic              vld_p0;
  logic              vld_p1;
  logic [2:0]        vld_nxt;

  logic [WIDTH-1:0]  a_p0;
  logic [WIDTH-1:0]  b_p0;
  logic              tc_p0;
  pair_t             red_p0;
  logic [PWIDTH-1:0] sum_p1;
  logic [PWIDTH-1:0] cry_p1;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // The valid flags form a 3-bit shift register. Each flag enters the stage
  // in step with its data, and occ is registered from the same next value.
  always_comb begin
    vld_nxt = {out_valid, vld_p1, vld_p0};
    if (adv)
      vld_nxt = {vld_p1, vld_p0, in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      occ       <= 2'd0;
    end else begin
      vld_p0    <= vld_nxt[0];
      vld_p1    <= vld_nxt[1];
      out_valid <= vld_nxt[2];
      occ       <= popcount3(vld_nxt);
    end
  end

  // ---- S1: operand capture -------------------------------------------------
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      a_p0  <= a;
      b_p0  <= b;
      tc_p0 <= tc;
    end
  end

  always_comb red_p0 = wallace_reduce(bw_rows(a_p0, b_p0, tc_p0));

  // ---- S2: carry-save rows -------------------------------------------------
  always_ff @(posedge clk) begin
    if (adv && vld_p0) begin
      sum_p1 <= red_p0[0];
      cry_p1 <= red_p0[1];
    end
  end

  // ---- S3: carry-propagate sum ---------------------------------------------
  // z loads only when a valid entry arrives. Otherwise it keeps the last
  // valid product, and a bubble never changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      z <= '0;
    else if (adv && vld_p1)
      z <= sum_p1 + cry_p1;
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_wallace_mult_pipe
//
// Directed bench for wallace_mult_pipe with WIDTH = 16. Inputs are driven
// 1 ns after each rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_wallace_mult_pipe;

  localparam int W  = 16;
  localparam int PW = 32;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic [W-1:0]  a         = '0;
  logic [W-1:0]  b         = '0;
  logic          tc        = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [PW-1:0] z;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    occ;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          tc;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  always #5 clk = ~clk;

  wallace_mult_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .tc        (tc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occ       (occ)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_tests++; if (z !== 32'h0) begin n_fail++; $display("FAIL reset z: got %h expected 00000000", z); end
    n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset occ: got %0d expected 0", occ); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held out_valid: got %b expected 0", out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_products;
    vec_t tv[7];
    tv[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tv[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    tv[2] = '{1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
    tv[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    tv[4] = '{1'b0, 16'h8000, 16'h7FFF, 32'h3FFF8000};
    tv[5] = '{1'b1, 16'h1234, 16'hFFFE, 32'hFFFFDB98};
    tv[6] = '{1'b0, 16'h0000, 16'h0000, 32'h00000000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tc = tv[i].tc; a = tv[i].a; b = tv[i].b; in_valid = 1'b1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL products[%0d] in_ready: got %b expected 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL products[%0d] early out_valid: got %b expected 0", i, out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL products[%0d] out_valid: got %b expected 1", i, out_valid); end
      n_tests++; if (z !== tv[i].p) begin n_fail++; $display("FAIL products[%0d] z: got %h expected %h", i, z, tv[i].p); end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] va[3];
    va[0] = 16'h0001; va[1] = 16'h1001; va[2] = 16'h0000;
    out_ready = 1'b1;
    tc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = (i == 2) ? 16'hFFFF : va[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_tests++; if (z !== 32'h1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b first z/out_valid: got %h/%b expected 00000001/1", z, out_valid); end
    n_tests++; if (occ !== 2'd3) begin n_fail++; $display("FAIL b2b full occ: got %0d expected 3", occ); end
    out_ready = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b stall in_ready: got %b expected 0", in_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++; if (z !== 32'h1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b hold[%0d] z/out_valid: got %h/%b expected 00000001/1", c, z, out_valid); end
      n_tests++; if (occ !== 2'd3) begin n_fail++; $display("FAIL b2b hold[%0d] occ: got %0d expected 3", c, occ); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b hold[%0d] in_ready: got %b expected 0", c, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b release in_ready: got %b expected 1", in_ready); end
    tick();
    n_tests++; if (z !== 32'h01002001 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b second z/out_valid: got %h/%b expected 01002001/1", z, out_valid); end
    n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL b2b second occ: got %0d expected 2", occ); end
    tick();
    n_tests++; if (z !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b third z/out_valid: got %h/%b expected 00000000/1", z, out_valid); end
    n_tests++; if (occ !== 2'd1) begin n_fail++; $display("FAIL b2b third occ: got %0d expected 1", occ); end
    tick();
    n_tests++; if (out_valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL b2b drained out_valid/occ: got %b/%0d expected 0/0", out_valid, occ); end
  endtask

  task automatic test_throughput;
    vec_t tv[6];
    tv[0] = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F};
    tv[1] = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
    tv[2] = '{1'b0, 16'hFFFD, 16'h0005, 32'h0004FFF1};
    tv[3] = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tv[4] = '{1'b0, 16'h0100, 16'h0100, 32'h00010000};
    tv[5] = '{1'b1, 16'h0002, 16'h8000, 32'hFFFF0000};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        tc = tv[k].tc; a = tv[k].a; b = tv[k].b; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 2) begin
        n_tests++; if (out_valid !== 1'b1 || z !== tv[k-2].p) begin n_fail++; $display("FAIL stream[%0d] z/out_valid: got %h/%b expected %h/1", k - 2, z, out_valid, tv[k-2].p); end
      end
      if (k >= 2 && k < 6) begin
        n_tests++; if (occ !== 2'd3) begin n_fail++; $display("FAIL stream occ at step %0d: got %0d expected 3", k, occ); end
      end
    end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream drained out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b1;
    tc = 1'b0; a = 16'h00FF; b = 16'h00FF; in_valid = 1'b1;
    tick();
    a = 16'h0011; b = 16'h0022;
    tick();
    in_valid = 1'b0;
    n_tests++; if (occ !== 2'd2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midflight occ/out_valid: got %0d/%b expected 2/0", occ, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (z !== 32'h0) begin n_fail++; $display("FAIL midflight reset z: got %h expected 00000000", z); end
    n_tests++; if (out_valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL midflight reset out_valid/occ: got %b/%0d expected 0/0", out_valid, occ); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midflight reset in_ready: got %b expected 1", in_ready); end
    tick();
    rst_n = 1'b1;
    tc = 1'b1; a = 16'hFFFE; b = 16'h0003; in_valid = 1'b1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (occ !== 2'd1) begin n_fail++; $display("FAIL post-reset accept occ: got %0d expected 1", occ); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post-reset stale out_valid: got %b expected 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || z !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL post-reset z/out_valid: got %h/%b expected FFFFFFFA/1", z, out_valid); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++; if (out_valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL post-reset idle[%0d] out_valid/occ: got %b/%0d expected 0/0", c, out_valid, occ); end
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_back_to_back();
    test_throughput();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
